// File: rtl/types.sv
// Shared datapath type definitions.
//   reg_type: microcode destination / source register selector.
//   Encodings are stable; new selectors must be appended at the end.
package types;

    typedef enum logic [4:0] {
        REG_A           = 5'd0,
        REG_B           = 5'd1,
        REG_TEMPA       = 5'd2,
        REG_TEMPB       = 5'd3,
        REG_XL          = 5'd4,
        REG_XH          = 5'd5,
        REG_XP          = 5'd6,
        REG_YL          = 5'd7,
        REG_YH          = 5'd8,
        REG_YP          = 5'd9,
        REG_SPL         = 5'd10,
        REG_SPH         = 5'd11,
        REG_FLAGS       = 5'd12,
        REG_MX          = 5'd13,
        REG_MY          = 5'd14,
        REG_MSP         = 5'd15,
        REG_MSP_INC     = 5'd16,
        REG_MN          = 5'd17,
        REG_ALU         = 5'd18,
        REG_IMM         = 5'd19,
        REG_IMM_HI      = 5'd20,
        REG_PCL         = 5'd21,
        REG_PCM         = 5'd22,
        REG_PCH         = 5'd23,
        REG_HARDCODED_1 = 5'd24
    } reg_type;

endpackage

// File: rtl/reg_writeback_if.sv
// Writeback stage bundle: microcode control and transfer nibble in, register file
// contents and nibble memory write port out.
//   slave  : the writeback stage (consumes controls, drives registers / mem write)
//   master : the sequencer / source-select side
interface reg_writeback_if;
    import types::*;

    logic        clk_2x_en;
    logic        is_transfer;
    reg_type     dest;
    logic [3:0]  bus_in;
    logic [3:0]  alu_flags;
    logic        alu_flags_wr;
    logic        inc_x;
    logic        inc_y;
    logic        inc_sp;
    logic        dec_sp;

    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  temp_a;
    logic [3:0]  temp_b;
    logic [11:0] x;
    logic [11:0] y;
    logic [7:0]  sp;
    logic [3:0]  flags;
    logic        mem_wr;
    logic [11:0] mem_wr_addr;
    logic [3:0]  mem_wr_data;

    modport master (
        output clk_2x_en, is_transfer, dest, bus_in, alu_flags, alu_flags_wr,
               inc_x, inc_y, inc_sp, dec_sp,
        input  a, b, temp_a, temp_b, x, y, sp, flags, mem_wr, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  clk_2x_en, is_transfer, dest, bus_in, alu_flags, alu_flags_wr,
               inc_x, inc_y, inc_sp, dec_sp,
        output a, b, temp_a, temp_b, x, y, sp, flags, mem_wr, mem_wr_addr, mem_wr_data
    );

endinterface

// File: rtl/reg_writeback.sv
// Destination half of the datapath: commits the transfer nibble to the selected register
// or issues a one-cycle nibble memory write; applies X/Y/SP post-inc / pre-dec.
// Ports: clk, reset (sync, active-high), wb (reg_writeback_if.slave). Latency 1 enable.
module reg_writeback
    import types::*;
#(
    parameter logic [7:0] SP_RESET   = 8'h00,
    parameter logic [3:0] FLAGS_MASK = 4'hF
) (
    input  logic           clk,
    input  logic           reset,
    reg_writeback_if.slave wb
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STROBE = 1'b1;

    logic [3:0]  a_q, b_q, ta_q, tb_q, flags_q;
    logic [11:0] x_q, y_q;
    logic [7:0]  sp_q;
    logic [0:0]  st_q;
    logic [11:0] addr_q;
    logic [3:0]  data_q;

    logic [3:0]  a_d, b_d, ta_d, tb_d, flags_d;
    logic [11:0] x_d, y_d;
    logic [7:0]  sp_d;
    logic [7:0]  sp_p1;
    logic [0:0]  st_d;
    logic [11:0] addr_d;
    logic [3:0]  data_d;
    logic        mem_req;

    assign sp_p1 = sp_q + 8'h01;

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        ta_d    = ta_q;
        tb_d    = tb_q;
        x_d     = x_q;
        y_d     = y_q;
        sp_d    = sp_q;
        flags_d = flags_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mem_req = 1'b0;

        // Index/stack updates first; a direct nibble write below overrides the whole
        // register, which discards the inc/dec for that register only.
        if (wb.inc_x) x_d[7:0] = x_q[7:0] + 8'h01;
        if (wb.inc_y) y_d[7:0] = y_q[7:0] + 8'h01;
        if (wb.inc_sp && !wb.dec_sp) sp_d = sp_p1;
        if (wb.dec_sp && !wb.inc_sp) sp_d = sp_q - 8'h01;

        if (wb.alu_flags_wr)
            flags_d = (wb.alu_flags & FLAGS_MASK) | (flags_q & ~FLAGS_MASK);

        if (wb.is_transfer) begin
            case (wb.dest)
                REG_A:     a_d  = wb.bus_in;
                REG_B:     b_d  = wb.bus_in;
                REG_TEMPA: ta_d = wb.bus_in;
                REG_TEMPB: tb_d = wb.bus_in;
                REG_XL:    x_d  = {x_q[11:4], wb.bus_in};
                REG_XH:    x_d  = {x_q[11:8], wb.bus_in, x_q[3:0]};
                REG_XP:    x_d  = {wb.bus_in, x_q[7:0]};
                REG_YL:    y_d  = {y_q[11:4], wb.bus_in};
                REG_YH:    y_d  = {y_q[11:8], wb.bus_in, y_q[3:0]};
                REG_YP:    y_d  = {wb.bus_in, y_q[7:0]};
                REG_SPL:   sp_d = {sp_q[7:4], wb.bus_in};
                REG_SPH:   sp_d = {wb.bus_in, sp_q[3:0]};
                REG_FLAGS: flags_d = (wb.bus_in & FLAGS_MASK) | (flags_q & ~FLAGS_MASK);
                // Memory destinations address with the pre-update pointer values.
                REG_MX: begin
                    mem_req = 1'b1;
                    addr_d  = x_q;
                    data_d  = wb.bus_in;
                end
                REG_MY: begin
                    mem_req = 1'b1;
                    addr_d  = y_q;
                    data_d  = wb.bus_in;
                end
                REG_MSP: begin
                    mem_req = 1'b1;
                    addr_d  = {4'h0, sp_q};
                    data_d  = wb.bus_in;
                end
                REG_MSP_INC: begin
                    mem_req = 1'b1;
                    addr_d  = {4'h0, sp_p1};
                    data_d  = wb.bus_in;
                end
                // The immediate nibble is what the source stage holds on the bus this step.
                REG_MN: begin
                    mem_req = 1'b1;
                    addr_d  = {8'h00, wb.bus_in};
                    data_d  = wb.bus_in;
                end
                default: ;
            endcase
        end

        st_d = mem_req ? STROBE : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            ta_q    <= 4'h0;
            tb_q    <= 4'h0;
            x_q     <= 12'h000;
            y_q     <= 12'h000;
            sp_q    <= SP_RESET;
            flags_q <= 4'h0;
            st_q    <= IDLE;
            addr_q  <= 12'h000;
            data_q  <= 4'h0;
        end else if (wb.clk_2x_en) begin
            a_q     <= a_d;
            b_q     <= b_d;
            ta_q    <= ta_d;
            tb_q    <= tb_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sp_q    <= sp_d;
            flags_q <= flags_d;
            st_q    <= st_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign wb.a           = a_q;
    assign wb.b           = b_q;
    assign wb.temp_a      = ta_q;
    assign wb.temp_b      = tb_q;
    assign wb.x           = x_q;
    assign wb.y           = y_q;
    assign wb.sp          = sp_q;
    assign wb.flags       = flags_q;
    assign wb.mem_wr      = (st_q == STROBE);
    assign wb.mem_wr_addr = addr_q;
    assign wb.mem_wr_data = data_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: hand-computed vectors, immediate assertions.
module tb_reg_writeback;
    import types::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    reg_writeback_if wb ();

    reg_writeback #(.SP_RESET(8'h00), .FLAGS_MASK(4'hF)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wb.clk_2x_en    = 1'b1;
        wb.is_transfer  = 1'b0;
        wb.dest         = REG_ALU;
        wb.bus_in       = 4'h0;
        wb.alu_flags    = 4'h0;
        wb.alu_flags_wr = 1'b0;
        wb.inc_x        = 1'b0;
        wb.inc_y        = 1'b0;
        wb.inc_sp       = 1'b0;
        wb.dec_sp       = 1'b0;
    endtask

    // One enabled transfer step, controls cleared afterwards.
    task automatic xfer(input reg_type d, input logic [3:0] v);
        wb.is_transfer = 1'b1;
        wb.dest        = d;
        wb.bus_in      = v;
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // 1: load nonzero state, then reset with the enable low
        xfer(REG_SPL, 4'hC);
        xfer(REG_SPH, 4'h3);
        xfer(REG_XL, 4'hC);
        xfer(REG_XH, 4'hB);
        xfer(REG_XP, 4'hA);
        xfer(REG_FLAGS, 4'h5);
        check("preload_sp", {4'h0, wb.sp}, 12'h03C);
        check("preload_x", wb.x, 12'hABC);
        wb.clk_2x_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wb.clk_2x_en = 1'b1;
        check("rst_sp", {4'h0, wb.sp}, 12'h000);
        check("rst_x", wb.x, 12'h000);
        check("rst_flags", {8'h0, wb.flags}, 12'h000);
        check("rst_mem_wr", {11'h0, wb.mem_wr}, 12'h000);
        check("rst_addr", wb.mem_wr_addr, 12'h000);

        // 2: nibble write, held off by the enable
        xfer(REG_XL, 4'h3);
        xfer(REG_XH, 4'h2);
        xfer(REG_XP, 4'h1);
        check("x_123", wb.x, 12'h123);
        wb.clk_2x_en   = 1'b0;
        wb.is_transfer = 1'b1;
        wb.dest        = REG_XH;
        wb.bus_in      = 4'h7;
        tick();
        tick();
        check("x_hold", wb.x, 12'h123);
        wb.clk_2x_en = 1'b1;
        tick();
        idle();
        check("x_xh7", wb.x, 12'h173);
        xfer(REG_A, 4'hD);
        xfer(REG_TEMPB, 4'h6);
        check("a_d", {8'h0, wb.a}, 12'h00D);
        check("tempb_6", {8'h0, wb.temp_b}, 12'h006);

        // 3: increments and wrap
        xfer(REG_XH, 4'hF);
        xfer(REG_XL, 4'hF);
        xfer(REG_XP, 4'h4);
        wb.inc_x = 1'b1;
        tick();
        idle();
        check("inc_x_wrap", wb.x, 12'h400);
        wb.dec_sp = 1'b1;
        tick();
        idle();
        check("dec_sp_wrap", {4'h0, wb.sp}, 12'h0FF);
        wb.inc_sp = 1'b1;
        wb.dec_sp = 1'b1;
        tick();
        idle();
        check("inc_dec_sp", {4'h0, wb.sp}, 12'h0FF);

        // 4: MSP_INC wraps SP+1 in 8 bits; strobe lasts one enable, addr/data hold
        xfer(REG_MSP_INC, 4'h9);
        check("msp_inc_wr", {11'h0, wb.mem_wr}, 12'h001);
        check("msp_inc_addr", wb.mem_wr_addr, 12'h000);
        check("msp_inc_data", {8'h0, wb.mem_wr_data}, 12'h009);
        check("msp_inc_sp", {4'h0, wb.sp}, 12'h0FF);
        tick();
        check("strobe_drop", {11'h0, wb.mem_wr}, 12'h000);
        check("addr_hold", wb.mem_wr_addr, 12'h000);
        check("data_hold", {8'h0, wb.mem_wr_data}, 12'h009);

        // 5: write beats inc for Y; X write with inc_y both apply
        xfer(REG_YL, 4'hF);
        check("y_00f", wb.y, 12'h00F);
        wb.inc_y = 1'b1;
        xfer(REG_YL, 4'h2);
        check("y_write_wins", wb.y, 12'h002);
        wb.inc_y = 1'b1;
        xfer(REG_XL, 4'h1);
        check("x_with_inc_y", wb.x, 12'h401);
        check("y_inc_applied", wb.y, 12'h003);
        wb.inc_sp = 1'b1;
        xfer(REG_SPL, 4'h7);
        check("sp_write_wins", {4'h0, wb.sp}, 12'h0F7);

        // 6: FLAGS transfer beats alu_flags_wr; alu path alone
        wb.alu_flags_wr = 1'b1;
        wb.alu_flags    = 4'h3;
        xfer(REG_FLAGS, 4'h8);
        check("flags_write_wins", {8'h0, wb.flags}, 12'h008);
        wb.alu_flags_wr = 1'b1;
        wb.alu_flags    = 4'h3;
        tick();
        idle();
        check("alu_flags", {8'h0, wb.flags}, 12'h003);

        // back-to-back memory writes keep the strobe high
        wb.is_transfer = 1'b1;
        wb.dest        = REG_MX;
        wb.bus_in      = 4'h5;
        tick();
        check("mx_wr", {11'h0, wb.mem_wr}, 12'h001);
        check("mx_addr", wb.mem_wr_addr, 12'h401);
        wb.dest   = REG_MY;
        wb.bus_in = 4'h6;
        tick();
        idle();
        check("my_wr", {11'h0, wb.mem_wr}, 12'h001);
        check("my_addr", wb.mem_wr_addr, 12'h003);
        check("my_data", {8'h0, wb.mem_wr_data}, 12'h006);

        // MSP uses pre-update SP while inc_sp applies
        wb.inc_sp = 1'b1;
        xfer(REG_MSP, 4'h1);
        check("msp_addr", wb.mem_wr_addr, 12'h0F7);
        check("msp_sp_inc", {4'h0, wb.sp}, 12'h0F8);
        xfer(REG_MN, 4'hA);
        check("mn_addr", wb.mem_wr_addr, 12'h00A);
        check("mn_data", {8'h0, wb.mem_wr_data}, 12'h00A);

        // read-only destination: no state change, strobe drops
        xfer(REG_PCL, 4'hF);
        check("ro_mem_wr", {11'h0, wb.mem_wr}, 12'h000);
        check("ro_a", {8'h0, wb.a}, 12'h00D);
        check("ro_x", wb.x, 12'h401);

        // reset while the strobe is high
        wb.is_transfer = 1'b1;
        wb.dest        = REG_MY;
        wb.bus_in      = 4'h4;
        tick();
        check("pre_rst_wr", {11'h0, wb.mem_wr}, 12'h001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check("midrst_wr", {11'h0, wb.mem_wr}, 12'h000);
        check("midrst_data", {8'h0, wb.mem_wr_data}, 12'h000);
        check("midrst_y", wb.y, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
